// File: rtl/demux_reg.sv
// demux_reg: registered 1-to-4 demultiplexer.
// One valid/ready input stream is steered by in_sel into one of four
// channels. Each channel has a one-entry holding register with its own
// handshake and a wrapping count of words delivered downstream.
module demux_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  // Per-channel state: valid flag (EMPTY/FULL), held word, delivered count.
  logic [3:0]       valid_q, valid_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [CNT_W-1:0] cnt_q  [4];
  logic [CNT_W-1:0] cnt_d  [4];

  logic       accept;
  logic [3:0] deliver;

  // Input handshake: the addressed channel can take a word if it is empty
  // or is being drained this same cycle. No path from in_valid.
  always_comb begin
    in_ready = !valid_q[in_sel] | out_ready[in_sel];
    accept   = in_valid & in_ready;
    deliver  = valid_q & out_ready;
  end

  // Next-state for each channel: accept wins over deliver so a
  // simultaneous drain and fill keeps the channel FULL with no bubble.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    valid_d = valid_q;
    for (int i = 0; i < 4; i++) begin
      data_d[i] = data_q[i];
      cnt_d[i]  = cnt_q[i];
      if (accept && (in_sel == 2'(i))) begin
        valid_d[i] = 1'b1;
        data_d[i]  = in_data;
      end else if (deliver[i]) begin
        // Data register keeps its stale value; only the flag drops.
        valid_d[i] = 1'b0;
      end
      if (deliver[i]) begin
        // Free-running wrap at 2^CNT_W, never saturates.
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // State register: asynchronous clear of flags, data and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < 4; i++) begin
        // NOTE: the data registers are reset too, not just the valid
        // flags, because the outputs must read zero during reset.
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      valid_q <= valid_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  // Output mapping from the internal arrays to the flat channel ports.
  always_comb begin
    out_valid = valid_q;
    out0 = data_q[0];
    out1 = data_q[1];
    out2 = data_q[2];
    out3 = data_q[3];
    cnt0 = cnt_q[0];
    cnt1 = cnt_q[1];
    cnt2 = cnt_q[2];
    cnt3 = cnt_q[3];
  end

endmodule

// File: tb/tb_demux_reg.sv
// tb_demux_reg: directed test of the registered 1-to-4 demultiplexer.
module tb_demux_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_sel;
  logic [7:0] in_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out0, out1, out2, out3;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;

  int compared   = 0;
  int mismatched = 0;

  demux_reg #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d,
                       input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    #1;
  endtask

  // Fill all channels, assert reset mid-cycle, expect immediate clear.
  task automatic test_reset();
    logic [7:0] w [4];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), w[i], 4'h0);
      cycle();
    end
    drive(1'b1, 2'd0, 8'h55, 4'b0001);  // drain+fill ch0 so cnt0 = 1
    cycle();
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    compared++;
    if (out_valid !== 4'hF || cnt0 !== 8'd1) begin
      mismatched++;
      $display("FAIL pre_reset_state out_valid=%b cnt0=%0d want 1111/1", out_valid, cnt0);
    end
    #1 rst = 1'b0;
    #1;
    compared++;
    if (out_valid !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_out_valid got=%b want=0000", out_valid);
    end
    compared++;
    if ({out0, out1, out2, out3} !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_data got=%h want=00000000", {out0, out1, out2, out3});
    end
    compared++;
    if ({cnt0, cnt1, cnt2, cnt3} !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_cnt got=%h want=00000000", {cnt0, cnt1, cnt2, cnt3});
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    #1 rst = 1'b1;
    cycle();
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 4'h0) begin
      mismatched++;
      $display("FAIL post_reset in_ready=%b out_valid=%b want 1/0000", in_ready, out_valid);
    end
  endtask

  task automatic test_steering();
    logic [7:0] w [4];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), w[i], 4'h0);
      cycle();
    end
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    compared++;
    if (out_valid !== 4'hF) begin
      mismatched++;
      $display("FAIL steer_out_valid got=%b want=1111", out_valid);
    end
    compared++;
    if ({out0, out1, out2, out3} !== 32'h11223344) begin
      mismatched++;
      $display("FAIL steer_data got=%h want=11223344", {out0, out1, out2, out3});
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 8'hEE, 4'h0);
      compared++;
      if (in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL steer_in_ready_sel%0d got=%b want=0", i, in_ready);
      end
    end
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    compared++;
    if ({cnt0, cnt1, cnt2, cnt3} !== 32'h0) begin
      mismatched++;
      $display("FAIL steer_cnt got=%h want=00000000", {cnt0, cnt1, cnt2, cnt3});
    end
  endtask

  // Channel 2 stalled must not block channel 0.
  task automatic test_blocking();
    drive(1'b0, 2'd0, 8'h00, 4'b0001);  // drain ch0 only, cnt0 -> 1
    cycle();
    drive(1'b1, 2'd2, 8'h99, 4'h0);
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL block_in_ready_sel2 got=%b want=0", in_ready);
    end
    for (int k = 0; k < 5; k++) begin
      cycle();
      compared++;
      if (out2 !== 8'h33 || out_valid[2] !== 1'b1) begin
        mismatched++;
        $display("FAIL block_out2_cyc%0d got=%h v=%b want=33 v=1", k, out2, out_valid[2]);
      end
    end
    drive(1'b1, 2'd0, 8'h77, 4'h0);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL block_in_ready_sel0 got=%b want=1", in_ready);
    end
    cycle();
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    compared++;
    if (out0 !== 8'h77 || out_valid !== 4'hF || cnt0 !== 8'd1) begin
      mismatched++;
      $display("FAIL block_land_ch0 out0=%h out_valid=%b cnt0=%0d want 77/1111/1",
               out0, out_valid, cnt0);
    end
  endtask

  task automatic test_drain_fill();
    drive(1'b1, 2'd1, 8'hA5, 4'b0010);  // ch1 holds 0x22 -> replaced by A5
    cycle();
    compared++;
    if (out1 !== 8'hA5 || out_valid[1] !== 1'b1 || cnt1 !== 8'd1) begin
      mismatched++;
      $display("FAIL fill_a5 out1=%h v=%b cnt1=%0d want A5/1/1", out1, out_valid[1], cnt1);
    end
    drive(1'b1, 2'd1, 8'h5A, 4'b0010);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL drainfill_in_ready got=%b want=1", in_ready);
    end
    cycle();
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    compared++;
    if (out1 !== 8'h5A || out_valid[1] !== 1'b1 || cnt1 !== 8'd2) begin
      mismatched++;
      $display("FAIL drainfill out1=%h v=%b cnt1=%0d want 5A/1/2", out1, out_valid[1], cnt1);
    end
  endtask

  // 16 words into ch3 (which already holds 0x44) with out_ready[3] high.
  task automatic test_back_to_back();
    logic [7:0] word;
    for (int k = 0; k < 16; k++) begin
      word = 8'hC0 + 8'(k);
      drive(1'b1, 2'd3, word, 4'b1000);
      compared++;
      if (in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL stream_in_ready_%0d got=%b want=1", k, in_ready);
      end
      cycle();
      compared++;
      if (out3 !== word || out_valid[3] !== 1'b1) begin
        mismatched++;
        $display("FAIL stream_out3_%0d got=%h v=%b want=%h v=1", k, out3, out_valid[3], word);
      end
    end
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    compared++;
    if (cnt3 !== 8'd16) begin
      mismatched++;
      $display("FAIL stream_cnt3 got=%0d want=16", cnt3);
    end
  endtask

  // From reset: 257 words through ch0; deliveries at edges 2..258.
  task automatic test_wrap();
    apply_reset();
    for (int e = 1; e <= 258; e++) begin
      drive(e <= 257, 2'd0, 8'(e), 4'b0001);
      cycle();
      if (e == 256 || e == 257 || e == 258) begin
        compared++;
        if (cnt0 !== 8'(e - 1)) begin
          mismatched++;
          $display("FAIL wrap_cnt0_delivery%0d got=%0d want=%0d", e - 1, cnt0, (e - 1) % 256);
        end
      end
    end
    drive(1'b0, 2'd0, 8'h00, 4'b1111);  // ready on empty channels: no effect
    cycle();
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    compared++;
    if ({cnt0, cnt1, cnt2, cnt3} !== 32'h01000000 || out_valid !== 4'h0) begin
      mismatched++;
      $display("FAIL wrap_final cnt=%h out_valid=%b want 01000000/0000",
               {cnt0, cnt1, cnt2, cnt3}, out_valid);
    end
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_steering();
    test_blocking();
    test_drain_fill();
    test_back_to_back();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
